// File: rtl/divide_unit.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, WIDTH-cycle latency.
// Optional DIVIDE_DBZ_FLAG_EN adds a registered div_by_zero flag that is updated with each done.
module divide_unit #(
  parameter  int WIDTH  = 8,
  parameter  int DRANGE = 4,
  localparam int DW     = $clog2(DRANGE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] numerator,
  input  logic [DW-1:0]    denominator,
  output logic [WIDTH-1:0] quotient,
  output logic [DW-1:0]    remain,
  output logic             busy,
  output logic             done
`ifdef DIVIDE_DBZ_FLAG_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] num_reg, num_next;
  logic [DW-1:0]    den_reg, den_next;
  logic [DW-1:0]    rem_reg, rem_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [DW-1:0]    remain_reg, remain_next;
  logic             done_reg, done_next;
`ifdef DIVIDE_DBZ_FLAG_EN
  logic             dbz_reg, dbz_next;
`endif

  // The partial remainder stays below the divisor, so DW bits hold it and
  // only the shifted trial value needs one extra bit.
  logic [DW:0]      shifted;
  logic             fits;
  logic [DW-1:0]    diff;
  logic [DW-1:0]    rem_step;
  logic [WIDTH-1:0] q_step;

  assign shifted  = {rem_reg, num_reg[WIDTH-1]};
  assign fits     = shifted >= {1'b0, den_reg};
  assign diff     = shifted[DW-1:0] - den_reg;
  assign rem_step = fits ? diff : shifted[DW-1:0];
  assign q_step   = {q_reg[WIDTH-2:0], fits};

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    num_next      = num_reg;
    den_next      = den_reg;
    rem_next      = rem_reg;
    q_next        = q_reg;
    quotient_next = quotient_reg;
    remain_next   = remain_reg;
    done_next     = 1'b0;
`ifdef DIVIDE_DBZ_FLAG_EN
    dbz_next      = dbz_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          num_next   = numerator;
          den_next   = denominator;
          rem_next   = '0;
          q_next     = '0;
          count_next = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        num_next   = num_reg << 1;
        rem_next   = rem_step;
        q_next     = q_step;
        count_next = count_reg + CW'(1);
        if (count_reg == LAST) begin
          state_next  = IDLE;
          count_next  = '0;
          done_next   = 1'b1;
          // A zero divisor always "fits", but the remainder is forced to 0.
          quotient_next = (den_reg == '0) ? '1 : q_step;
          remain_next   = (den_reg == '0) ? '0 : rem_step;
`ifdef DIVIDE_DBZ_FLAG_EN
          dbz_next      = (den_reg == '0);
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      num_reg      <= '0;
      den_reg      <= '0;
      rem_reg      <= '0;
      q_reg        <= '0;
      quotient_reg <= '0;
      remain_reg   <= '0;
      done_reg     <= 1'b0;
`ifdef DIVIDE_DBZ_FLAG_EN
      dbz_reg      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      num_reg      <= num_next;
      den_reg      <= den_next;
      rem_reg      <= rem_next;
      q_reg        <= q_next;
      quotient_reg <= quotient_next;
      remain_reg   <= remain_next;
      done_reg     <= done_next;
`ifdef DIVIDE_DBZ_FLAG_EN
      dbz_reg      <= dbz_next;
`endif
    end
  end

  assign quotient = quotient_reg;
  assign remain   = remain_reg;
  assign busy     = (state_reg == RUN);
  assign done     = done_reg;
`ifdef DIVIDE_DBZ_FLAG_EN
  assign div_by_zero = dbz_reg;
`endif

endmodule

// File: tb/tb_divide_unit.sv
// Directed self-checking bench for divide_unit (WIDTH=8, DRANGE=4).
module tb_divide_unit;
  localparam int WIDTH = 8;
  localparam int DW    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] numerator;
  logic [DW-1:0]    denominator;
  logic [WIDTH-1:0] quotient;
  logic [DW-1:0]    remain;
  logic             busy;
  logic             done;
`ifdef DIVIDE_DBZ_FLAG_EN
  logic             div_by_zero;
`endif

  int checks = 0;
  int errors = 0;

  divide_unit #(.WIDTH(WIDTH), .DRANGE(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .numerator(numerator),
    .denominator(denominator),
    .quotient(quotient),
    .remain(remain),
    .busy(busy),
    .done(done)
`ifdef DIVIDE_DBZ_FLAG_EN
    ,
    .div_by_zero(div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [WIDTH-1:0] n, input logic [DW-1:0] d);
    numerator   = n;
    denominator = d;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; numerator = '0; denominator = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL reset_quotient got %0d want 0", quotient); end
    checks++; if (remain !== 2'd0) begin errors++; $display("FAIL reset_remain got %0d want 0", remain); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    $display("reset: q=%0d r=%0d busy=%b done=%b", quotient, remain, busy, done);
  endtask

  task automatic test_basic();
    int cycles;
    launch(8'd19, 2'd3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      checks++;
      if (quotient !== 8'd0 || remain !== 2'd0) begin
        errors++; $display("FAIL basic_hold got q=%0d r=%0d want q=0 r=0", quotient, remain);
      end
      tick();
      cycles++;
    end
    checks++; if (cycles !== 8) begin errors++; $display("FAIL basic_latency got %0d want 8", cycles); end
    checks++; if (quotient !== 8'd6) begin errors++; $display("FAIL basic_quotient got %0d want 6", quotient); end
    checks++; if (remain !== 2'd1) begin errors++; $display("FAIL basic_remain got %0d want 1", remain); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_drop got %b want 0", busy); end
    $display("19/3: q=%0d r=%0d latency=%0d", quotient, remain, cycles);
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    checks++; if (quotient !== 8'd6) begin errors++; $display("FAIL basic_after_hold got %0d want 6", quotient); end
  endtask

  task automatic test_truncation();
    int cycles;
    launch(8'd19, DW'(5));
    wait_done(cycles);
    checks++; if (cycles !== 8) begin errors++; $display("FAIL trunc_latency got %0d want 8", cycles); end
    checks++; if (quotient !== 8'd19) begin errors++; $display("FAIL trunc_quotient got %0d want 19", quotient); end
    checks++; if (remain !== 2'd0) begin errors++; $display("FAIL trunc_remain got %0d want 0", remain); end
    $display("19/(5->1): q=%0d r=%0d latency=%0d", quotient, remain, cycles);
  endtask

  task automatic test_div_by_zero();
    int cycles;
    launch(8'd200, 2'd0);
    wait_done(cycles);
    checks++; if (cycles !== 8) begin errors++; $display("FAIL dbz_latency got %0d want 8", cycles); end
    checks++; if (quotient !== 8'd255) begin errors++; $display("FAIL dbz_quotient got %0d want 255", quotient); end
    checks++; if (remain !== 2'd0) begin errors++; $display("FAIL dbz_remain got %0d want 0", remain); end
`ifdef DIVIDE_DBZ_FLAG_EN
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b want 1", div_by_zero); end
`endif
    $display("200/0: q=%0d r=%0d latency=%0d", quotient, remain, cycles);
  endtask

  task automatic test_back_to_back();
    int cycles;
    launch(8'd100, 2'd3);
    tick(); tick();
    numerator = 8'd255; denominator = 2'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cycles);
    checks++; if (cycles !== 5) begin errors++; $display("FAIL ignore_latency got %0d want 5", cycles); end
    checks++; if (quotient !== 8'd33) begin errors++; $display("FAIL ignore_quotient got %0d want 33", quotient); end
    checks++; if (remain !== 2'd1) begin errors++; $display("FAIL ignore_remain got %0d want 1", remain); end
`ifdef DIVIDE_DBZ_FLAG_EN
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_clear got %b want 0", div_by_zero); end
`endif
    $display("100/3 (busy start ignored): q=%0d r=%0d", quotient, remain);
    numerator = 8'd255; denominator = 2'd2; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
    checks++; if (quotient !== 8'd33) begin errors++; $display("FAIL b2b_hold got %0d want 33", quotient); end
    wait_done(cycles);
    checks++; if (cycles !== 8) begin errors++; $display("FAIL b2b_latency got %0d want 8", cycles); end
    checks++; if (quotient !== 8'd127) begin errors++; $display("FAIL b2b_quotient got %0d want 127", quotient); end
    checks++; if (remain !== 2'd1) begin errors++; $display("FAIL b2b_remain got %0d want 1", remain); end
    $display("255/2 back-to-back: q=%0d r=%0d latency=%0d", quotient, remain, cycles);
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    launch(8'd200, 2'd3);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
    checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL midrst_quotient got %0d want 0", quotient); end
    checks++; if (remain !== 2'd0) begin errors++; $display("FAIL midrst_remain got %0d want 0", remain); end
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done got %b want 0", seen_done); end
    $display("reset mid-division: busy=%b q=%0d r=%0d", busy, quotient, remain);
  endtask

  task automatic test_start_in_reset();
    rst = 1'b1; start = 1'b1; numerator = 8'd19; denominator = 2'd3;
    tick();
    rst = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_start_busy got %b want 0", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_start_busy_later got %b want 0", busy); end
    $display("start during reset: busy=%b", busy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_truncation();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid();
    test_start_in_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divide_unit.md
DIVIDE_UNIT -- requirements
Module: divide

Interface
REQ-001 Parameter WIDTH, default 8, sets the bit width of numerator and quotient.
REQ-002 Parameter DRANGE, default 4, is the denominator value range; denominator/remain width DW = clog2(DRANGE) (2 at default).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request pulse; accepted only when busy=0.
REQ-006 numerator  input  WIDTH  dividend, unsigned.
REQ-007 denominator  input  DW  divisor, unsigned.
REQ-008 quotient  output  WIDTH  registered unsigned quotient.
REQ-009 remain  output  DW  registered unsigned remainder.
REQ-010 busy  output  1  high while a division is in progress.
REQ-011 done  output  1  one-cycle pulse when quotient/remain become valid.

Function
REQ-012 On a clk edge with start=1 and busy=0, the block SHALL capture numerator and denominator into internal registers and set busy=1.
REQ-013 The block SHALL compute the result by restoring shift-subtract, one quotient bit per cycle, MSB first.
REQ-014 Latency SHALL be exactly WIDTH cycles from the accepting edge to the edge asserting done (8 at default).
REQ-015 When done asserts, busy SHALL drop in the same cycle, and quotient/remain SHALL be updated to the new result in that cycle.
REQ-016 quotient and remain SHALL hold their last values until the next done; they SHALL not change while busy.
REQ-017 The result SHALL satisfy numerator = quotient*denominator + remain with remain < denominator for denominator != 0.
REQ-018 Inputs wider than the port SHALL be truncated by the port width; only the captured DW bits participate (e.g. 5 driven on a 2-bit port is 1).
REQ-019 start while busy=1 SHALL be ignored; captured operands SHALL not change.
REQ-020 start on the same edge as done SHALL be accepted as a new operation (back-to-back); done still pulses for the finished one.
REQ-021 Divide by zero SHALL take the full WIDTH cycles and yield quotient = all ones and remain = 0.
REQ-022 State machine: IDLE (busy=0) -> RUN on accepted start; RUN counts WIDTH steps -> IDLE asserting done.

Reset
REQ-023 rst=1 at a clk edge SHALL force state IDLE, busy=0, done=0, quotient=0, remain=0, and clear the internal counters.
REQ-024 rst SHALL take priority over start and abort any in-progress division without asserting done.
REQ-025 start SHALL be ignored in any cycle where rst=1.

Configuration
REQ-026 Macro DIVIDE_DBZ_FLAG_EN: when defined, the block SHALL add output div_by_zero (1 bit, registered), set to 1 with done when the captured denominator was 0, and cleared to 0 with every other done and by reset.
REQ-027 Without DIVIDE_DBZ_FLAG_EN, the div_by_zero port SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-028 Reset: rst=1 for 2 cycles -> quotient=0, remain=0, busy=0, done=0.
REQ-029 numerator=19, denominator=3, start pulse -> after 8 cycles done=1, quotient=6, remain=1.
REQ-030 numerator=19, denominator port driven with 5 (truncated to 1) -> quotient=19, remain=0.
REQ-031 numerator=200, denominator=0 -> quotient=255, remain=0, div_by_zero=1 when the macro is defined.
REQ-032 start again with numerator=255, denominator=2 while busy -> ignored; next start at the done edge with numerator=255, denominator=2 -> quotient=127, remain=1.
REQ-033 rst asserted mid-division (cycle 4) -> busy=0, no done pulse, outputs=0.
